// File: rtl/rtr_flags_lookup_if.sv
// rtr_flags_lookup_if: update, lookup request/response and flag-array signals of rtr_flags_lookup.
interface rtr_flags_lookup_if #(
    parameter int num_message_classes  = 2,
    parameter int num_resource_classes = 2,
    parameter int num_ports            = 5,
    parameter int width                = 1
);
    localparam int num_packet_classes = num_message_classes * num_resource_classes;
    logic                                          upd_valid;
    logic [num_ports-1:0]                          upd_op;
    logic [num_packet_classes-1:0]                 upd_pc;
    logic [width-1:0]                              upd_set;
    logic [width-1:0]                              upd_clr;
    logic                                          req_valid;
    logic                                          req_ready;
    logic [num_message_classes-1:0]                req_mc;
    logic [num_ports-1:0]                          req_op;
    logic [num_resource_classes-1:0]               req_orc;
    logic                                          resp_valid;
    logic                                          resp_ready;
    logic [width-1:0]                              resp_flags;
    logic                                          resp_error;
    logic [num_ports*num_packet_classes*width-1:0] flags_op_opc;

    modport master (
        output upd_valid, upd_op, upd_pc, upd_set, upd_clr,
        output req_valid, req_mc, req_op, req_orc, resp_ready,
        input  req_ready, resp_valid, resp_flags, resp_error, flags_op_opc
    );

    modport slave (
        input  upd_valid, upd_op, upd_pc, upd_set, upd_clr,
        input  req_valid, req_mc, req_op, req_orc, resp_ready,
        output req_ready, resp_valid, resp_flags, resp_error, flags_op_opc
    );
endinterface

// File: rtl/rtr_flags_lookup.sv
// rtr_flags_lookup: registered output-VC flag array with set/clear updates and a one-deep lookup response stage.
// Define RTR_FLAGS_LOOKUP_BYPASS_EN to forward same-cycle updates into lookups.
module rtr_flags_lookup #(
    parameter int num_message_classes  = 2,
    parameter int num_resource_classes = 2,
    parameter int num_ports            = 5,
    parameter int width                = 1,
    parameter bit reset_value          = 1'b0
) (
    input logic               clk,
    input logic               reset,
    rtr_flags_lookup_if.slave bus
);
    localparam int npc = num_message_classes * num_resource_classes;
    localparam int nbits = num_ports * npc * width;

    logic [nbits-1:0] flags_q, flags_d, src;
    logic [width-1:0] hits [num_ports*npc];
    logic [width-1:0] sel;
    logic             upd_ok, req_err, accept;
    logic             resp_valid_q, resp_error_q;
    logic [width-1:0] resp_flags_q;

    assign upd_ok  = bus.upd_valid && $onehot(bus.upd_op) && $onehot(bus.upd_pc);
    assign req_err = !($onehot(bus.req_mc) && $onehot(bus.req_op) && $onehot(bus.req_orc));
    assign accept  = bus.req_valid && bus.req_ready;

    for (genvar p = 0; p < num_ports; p++) begin : g_p
        for (genvar c = 0; c < npc; c++) begin : g_c
            localparam int lo = (p * npc + c) * width;
            assign flags_d[lo +: width] = (upd_ok && bus.upd_op[p] && bus.upd_pc[c])
                ? (flags_q[lo +: width] | bus.upd_set) & ~(bus.upd_clr & ~bus.upd_set)
                : flags_q[lo +: width];
            // A one-hot request matches exactly one entry, so the hits can simply be OR-ed
            assign hits[p*npc+c] = (bus.req_op[p] && bus.req_mc[c/num_resource_classes]
                                    && bus.req_orc[c%num_resource_classes]) ? src[lo +: width] : '0;
        end
    end

`ifdef RTR_FLAGS_LOOKUP_BYPASS_EN
    assign src = flags_d;
`else
    assign src = flags_q;
`endif

    always_comb begin
        sel = '0;
        for (int i = 0; i < num_ports * npc; i++) sel = sel | hits[i];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q      <= {nbits{reset_value}};
            resp_valid_q <= 1'b0;
            resp_flags_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            if (accept) begin
                resp_valid_q <= 1'b1;
                resp_flags_q <= req_err ? '0 : sel;
                resp_error_q <= req_err;
            end else if (bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = !resp_valid_q || bus.resp_ready;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_flags   = resp_flags_q;
    assign bus.resp_error   = resp_error_q;
    assign bus.flags_op_opc = flags_q;
endmodule

// File: tb/tb_rtr_flags_lookup.sv
// tb_rtr_flags_lookup: directed checks of update, lookup, backpressure, error and reset behaviour.
module tb_rtr_flags_lookup;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    rtr_flags_lookup_if bus ();
    rtr_flags_lookup dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [1:0] mc, input logic [4:0] op, input logic [1:0] orc);
        bus.req_valid = v;
        bus.req_mc    = mc;
        bus.req_op    = op;
        bus.req_orc   = orc;
    endtask

    task automatic upd(input logic v, input logic [4:0] op, input logic [3:0] pc, input logic s, input logic c);
        bus.upd_valid  = v;
        bus.upd_op     = op;
        bus.upd_pc     = pc;
        bus.upd_set[0] = s;
        bus.upd_clr[0] = c;
    endtask

    initial begin
        req(1'b0, 2'b00, 5'b00000, 2'b00);
        upd(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);
        bus.resp_ready = 1'b0;
        tick;
        tick;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_flags", 32'(bus.resp_flags), 32'd0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        chk("rst_flags", 32'(bus.flags_op_opc), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        tick;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        // first lookup on a cleared array
        req(1'b1, 2'b01, 5'b00100, 2'b10);
        tick;
        req(1'b0, 2'b00, 5'b00000, 2'b00);
        chk("t1_valid", 32'(bus.resp_valid), 32'd1);
        chk("t1_flags", 32'(bus.resp_flags), 32'd0);
        chk("t1_error", 32'(bus.resp_error), 32'd0);
        chk("t1_array", 32'(bus.flags_op_opc), 32'h0);
        tick;
        chk("t1_drain", 32'(bus.resp_valid), 32'd0);
        // port 1, pc 2 (mc 1, rc 0) -> array bit 6
        upd(1'b1, 5'b00010, 4'b0100, 1'b1, 1'b0);
        tick;
        upd(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);
        chk("t2_array", 32'(bus.flags_op_opc), 32'h40);
        req(1'b1, 2'b10, 5'b00010, 2'b01);
        tick;
        chk("t2_hit_valid", 32'(bus.resp_valid), 32'd1);
        chk("t2_hit_flags", 32'(bus.resp_flags), 32'd1);
        req(1'b1, 2'b10, 5'b00010, 2'b10);
        tick;
        req(1'b0, 2'b00, 5'b00000, 2'b00);
        chk("t2_b2b_valid", 32'(bus.resp_valid), 32'd1);
        chk("t2_other_rc", 32'(bus.resp_flags), 32'd0);
        tick;
        // set wins over clear, then clear alone
        upd(1'b1, 5'b00001, 4'b0001, 1'b1, 1'b1);
        tick;
        chk("t3_set_wins", 32'(bus.flags_op_opc), 32'h41);
        upd(1'b1, 5'b00001, 4'b0001, 1'b0, 1'b1);
        tick;
        chk("t3_clear", 32'(bus.flags_op_opc), 32'h40);
        upd(1'b1, 5'b00011, 4'b0001, 1'b1, 1'b0);
        tick;
        chk("t3_bad_op_ignored", 32'(bus.flags_op_opc), 32'h40);
        upd(1'b1, 5'b00001, 4'b0000, 1'b1, 1'b0);
        tick;
        upd(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);
        chk("t3_bad_pc_ignored", 32'(bus.flags_op_opc), 32'h40);
        // backpressure: hold a response of 1 while its entry is cleared
        bus.resp_ready = 1'b0;
        req(1'b1, 2'b10, 5'b00010, 2'b01);
        tick;
        chk("t4_valid", 32'(bus.resp_valid), 32'd1);
        chk("t4_flags", 32'(bus.resp_flags), 32'd1);
        req(1'b1, 2'b01, 5'b00001, 2'b01);
        upd(1'b1, 5'b00010, 4'b0100, 1'b0, 1'b1);
        #1;
        chk("t4_req_ready_low", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            upd(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);
            chk("t4_hold_flags", 32'(bus.resp_flags), 32'd1);
            chk("t4_hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
        end
        chk("t4_array_cleared", 32'(bus.flags_op_opc), 32'h0);
        bus.resp_ready = 1'b1;
        #1;
        chk("t4_ready_comb", 32'(bus.req_ready), 32'd1);
        tick;
        req(1'b0, 2'b00, 5'b00000, 2'b00);
        chk("t4_accept_valid", 32'(bus.resp_valid), 32'd1);
        chk("t4_accept_flags", 32'(bus.resp_flags), 32'd0);
        tick;
        chk("t4_drain", 32'(bus.resp_valid), 32'd0);
        // error cases; port 2 pc 2 (bit 10) is set so a masked result would be visible
        upd(1'b1, 5'b00100, 4'b0100, 1'b1, 1'b0);
        tick;
        upd(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);
        chk("t5_array", 32'(bus.flags_op_opc), 32'h400);
        req(1'b1, 2'b10, 5'b00110, 2'b01);
        tick;
        chk("t5_op_err", 32'(bus.resp_error), 32'd1);
        chk("t5_op_flags", 32'(bus.resp_flags), 32'd0);
        req(1'b1, 2'b00, 5'b00100, 2'b01);
        tick;
        chk("t5_mc_err", 32'(bus.resp_error), 32'd1);
        chk("t5_mc_flags", 32'(bus.resp_flags), 32'd0);
        req(1'b1, 2'b10, 5'b00100, 2'b11);
        tick;
        chk("t5_orc_err", 32'(bus.resp_error), 32'd1);
        req(1'b1, 2'b10, 5'b00100, 2'b01);
        tick;
        req(1'b0, 2'b00, 5'b00000, 2'b00);
        chk("t5_ok_err", 32'(bus.resp_error), 32'd0);
        chk("t5_ok_flags", 32'(bus.resp_flags), 32'd1);
        tick;
        // same-cycle update and lookup of port 3 pc 0, then reset with the response pending
        bus.resp_ready = 1'b0;
        upd(1'b1, 5'b01000, 4'b0001, 1'b1, 1'b0);
        req(1'b1, 2'b01, 5'b01000, 2'b01);
        tick;
        upd(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);
        req(1'b0, 2'b00, 5'b00000, 2'b00);
        chk("t6_valid", 32'(bus.resp_valid), 32'd1);
`ifdef RTR_FLAGS_LOOKUP_BYPASS_EN
        chk("t6_bypass_flags", 32'(bus.resp_flags), 32'd1);
`else
        chk("t6_nobypass_flags", 32'(bus.resp_flags), 32'd0);
`endif
        chk("t6_array", 32'(bus.flags_op_opc), 32'h1400);
        reset = 1'b0;
        tick;
        chk("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("t6_rst_flags", 32'(bus.resp_flags), 32'd0);
        chk("t6_rst_array", 32'(bus.flags_op_opc), 32'h0);
        reset = 1'b1;
        tick;
        chk("t6_rel_valid", 32'(bus.resp_valid), 32'd0);
        chk("t6_rel_ready", 32'(bus.req_ready), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
